enemy_array: RTL and testbench

Parametrised enemy manager for the Zelda game core: holds position, facing and alive state for `NUM_ENEMIES` enemies and moves each one one step toward Link per game tick. It honours per-enemy collision blocking and sword hits, and serialises every live enemy's sprite into the VGA pixel-write stream. It sits between the game control FSM (init/gen_move/apply_move/draw pulses), the collision detector and the VGA adapter, and replaces the fixed three-enemy block.

---
 rtl/enemy_pkg.sv | 24 ++
 rtl/enemy_chase.sv | 101 ++++++++++
 rtl/enemy_array.sv | 143 ++++++++++++++
 tb/tb_enemy_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
// Shared constants for the enemy manager: direction codes, transparent colour,
// spawn layout and the draw FSM state encoding.
package enemy_pkg;

   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   localparam logic [5:0] TRANSPARENT = 6'h3F;

   localparam int SPAWN_X0 = 32;
   localparam int SPAWN_DX = 64;
   localparam int SPAWN_Y  = 32;

   typedef enum logic [1:0] {
      DRAW_IDLE  = 2'd0,
      DRAW_SCAN  = 2'd1,
      DRAW_FLUSH = 2'd2,
      DRAW_DONE  = 2'd3
   } draw_state_t;

endpackage

// File: rtl/enemy_chase.sv
// One enemy slot: picks a direction toward Link, steps with screen clamping,
// and tracks alive state under sword hits and collision blocking.
module enemy_chase
   import enemy_pkg::*;
#(
   parameter int INDEX       = 0,
   parameter int SPRITE_SIZE = 16,
   parameter int STEP        = 1,
   parameter int X_MAX       = 320,
   parameter int Y_MAX       = 240
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       init,
   input  logic       gen_move,
   input  logic       apply_move,
   input  logic [8:0] link_x,
   input  logic [7:0] link_y,
   input  logic       blocked,
   input  logic       hit,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic [2:0] direction,
   output logic [2:0] facing,
   output logic       alive
);

   localparam logic [8:0] SPAWN_XI = 9'(SPAWN_X0 + SPAWN_DX * INDEX);
   localparam logic [7:0] SPAWN_YI = 8'(SPAWN_Y);
   localparam logic signed [11:0] STEP_S = 12'(STEP);
   localparam logic signed [11:0] X_LIM  = 12'(X_MAX - SPRITE_SIZE);
   localparam logic signed [11:0] Y_LIM  = 12'(Y_MAX - SPRITE_SIZE);

   logic signed [9:0]  dx, dy;
   logic [9:0]         adx, ady;
   logic [2:0]         want;
   logic signed [11:0] nx, ny;
   logic [8:0]         x_next;
   logic [7:0]         y_next;

   always_comb begin
      dx  = {1'b0, link_x} - {1'b0, x};
      dy  = {2'b00, link_y} - {2'b00, y};
      adx = dx[9] ? 10'(-dx) : 10'(dx);
      ady = dy[9] ? 10'(-dy) : 10'(dy);
      want = DIR_NONE;
      // Ties on magnitude resolve to horizontal movement.
      if (dx != 10'sd0 && adx >= ady) begin
         want = dx[9] ? DIR_LEFT : DIR_RIGHT;
      end else if (dy != 10'sd0) begin
         want = dy[9] ? DIR_UP : DIR_DOWN;
      end
   end

   always_comb begin
      nx = {3'b000, x};
      ny = {4'b0000, y};
      case (direction)
         DIR_UP:    ny = ny - STEP_S;
         DIR_DOWN:  ny = ny + STEP_S;
         DIR_LEFT:  nx = nx - STEP_S;
         DIR_RIGHT: nx = nx + STEP_S;
         default:   ;
      endcase
      if (nx[11])          x_next = 9'd0;
      else if (nx > X_LIM) x_next = X_LIM[8:0];
      else                 x_next = nx[8:0];
      if (ny[11])          y_next = 8'd0;
      else if (ny > Y_LIM) y_next = Y_LIM[7:0];
      else                 y_next = ny[7:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x         <= '0;
         y         <= '0;
         alive     <= 1'b0;
         direction <= DIR_NONE;
         facing    <= DIR_DOWN;
      end else if (init) begin
         x         <= SPAWN_XI;
         y         <= SPAWN_YI;
         alive     <= 1'b1;
         direction <= DIR_NONE;
         facing    <= DIR_DOWN;
      end else if (gen_move) begin
         direction <= alive ? want : DIR_NONE;
         if (alive && want != DIR_NONE) facing <= want;
      end else if (apply_move) begin
         // A hit outranks blocking: the enemy dies where it stands.
         if (hit) begin
            alive <= 1'b0;
         end else if (alive && !blocked) begin
            x <= x_next;
            y <= y_next;
         end
         direction <= DIR_NONE;
      end
   end

endmodule

// File: rtl/enemy_array.sv
// Enemy manager: NUM_ENEMIES chase slots plus a draw FSM that streams every
// live enemy's sprite through a 1-cycle synchronous ROM into VGA pixel writes.
module enemy_array
   import enemy_pkg::*;
#(
   parameter int NUM_ENEMIES = 3,
   parameter int SPRITE_SIZE = 16,
   parameter int STEP        = 1,
   parameter int X_MAX       = 320,
   parameter int Y_MAX       = 240
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               init,
   input  logic                               gen_move,
   input  logic                               apply_move,
   input  logic                               draw,
   input  logic [8:0]                         link_x_pos,
   input  logic [7:0]                         link_y_pos,
   input  logic [NUM_ENEMIES-1:0]             blocked,
   input  logic [NUM_ENEMIES-1:0]             hit,
   output logic [9*NUM_ENEMIES-1:0]           enemy_x_pos,
   output logic [8*NUM_ENEMIES-1:0]           enemy_y_pos,
   output logic [3*NUM_ENEMIES-1:0]           enemy_direction,
   output logic [3*NUM_ENEMIES-1:0]           enemy_facing,
   output logic [NUM_ENEMIES-1:0]             enemy_alive,
   output logic [2*$clog2(SPRITE_SIZE)+1:0]   rom_addr,
   input  logic [5:0]                         rom_data,
   output logic [8:0]                         x_draw,
   output logic [7:0]                         y_draw,
   output logic [5:0]                         colour,
   output logic                               VGA_write,
   output logic                               draw_done,
   output logic [1:0]                         draw_state
);

   localparam int LOG2SS = $clog2(SPRITE_SIZE);
   localparam int PIXW   = 2 * LOG2SS;
   localparam int IDXW   = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ENEMIES - 1);
   localparam logic [PIXW-1:0] LAST_PIX = '1;

   draw_state_t state_q, state_d;
   logic [IDXW-1:0] idx_q;
   logic [PIXW-1:0] pix_q;
   logic            pix_valid;
   logic            idle, cur_alive, cur_live, item_end, last_step;
   logic [8:0]      cur_x;
   logic [7:0]      cur_y;
   logic [2:0]      cur_facing, fac_m1;
   logic [LOG2SS-1:0] col, row;

   logic [8:0] ex [NUM_ENEMIES];
   logic [7:0] ey [NUM_ENEMIES];
   logic [2:0] ef [NUM_ENEMIES];
   logic       ea [NUM_ENEMIES];

   assign idle = (state_q == DRAW_IDLE);

   // Movement pulses are only honoured while no draw is in flight.
   for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_enemy
      enemy_chase #(
         .INDEX(g), .SPRITE_SIZE(SPRITE_SIZE), .STEP(STEP),
         .X_MAX(X_MAX), .Y_MAX(Y_MAX)
      ) u_chase (
         .clock(clock), .reset(reset),
         .init(init && idle), .gen_move(gen_move && idle), .apply_move(apply_move && idle),
         .link_x(link_x_pos), .link_y(link_y_pos),
         .blocked(blocked[g]), .hit(hit[g]),
         .x(ex[g]), .y(ey[g]), .direction(enemy_direction[3*g +: 3]),
         .facing(ef[g]), .alive(ea[g])
      );
      assign enemy_x_pos[9*g +: 9] = ex[g];
      assign enemy_y_pos[8*g +: 8] = ey[g];
      assign enemy_facing[3*g +: 3] = ef[g];
      assign enemy_alive[g] = ea[g];
   end

   assign cur_x      = ex[idx_q];
   assign cur_y      = ey[idx_q];
   assign cur_facing = ef[idx_q];
   assign cur_alive  = ea[idx_q];
   assign fac_m1     = cur_facing - 3'd1;
   assign col        = pix_q[LOG2SS-1:0];
   assign row        = pix_q[PIXW-1:LOG2SS];
   assign cur_live   = (state_q == DRAW_SCAN) && cur_alive;
   // A dead slot spends exactly one SCAN cycle; a live one spends SPRITE_SIZE^2.
   assign item_end   = !cur_alive || (pix_q == LAST_PIX);
   assign last_step  = (idx_q == LAST_IDX) && item_end;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= DRAW_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DRAW_IDLE:  if (draw) state_d = DRAW_SCAN;
         DRAW_SCAN:  if (last_step) state_d = DRAW_FLUSH;
         DRAW_FLUSH: state_d = DRAW_DONE;
         DRAW_DONE:  state_d = DRAW_IDLE;
         default:    state_d = DRAW_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_q <= '0;
         pix_q <= '0;
      end else if (state_q != DRAW_SCAN || last_step) begin
         idx_q <= '0;
         pix_q <= '0;
      end else if (item_end) begin
         idx_q <= idx_q + 1'b1;
         pix_q <= '0;
      end else begin
         pix_q <= pix_q + 1'b1;
      end
   end

   // Pixel coordinates are delayed one cycle so they line up with rom_data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_valid <= 1'b0;
         x_draw    <= '0;
         y_draw    <= '0;
      end else begin
         pix_valid <= cur_live;
         if (cur_live) begin
            x_draw <= cur_x + 9'(col);
            y_draw <= cur_y + 8'(row);
         end
      end
   end

   assign rom_addr   = cur_live ? {fac_m1[1:0], pix_q} : '0;
   assign VGA_write  = pix_valid && (rom_data != TRANSPARENT);
   assign colour     = pix_valid ? rom_data : 6'd0;
   assign draw_done  = (state_q == DRAW_DONE);
   assign draw_state = state_q;

endmodule

// File: tb/tb_enemy_array.sv
// Directed bench for enemy_array with N=3: spawn, chase, hit/block, clamp,
// full draw timing, dead-slot draw and reset during a draw.
module tb_enemy_array;

   logic        clock, reset;
   logic        init, gen_move, apply_move, draw;
   logic [8:0]  link_x_pos;
   logic [7:0]  link_y_pos;
   logic [2:0]  blocked, hit;
   logic [26:0] enemy_x_pos;
   logic [23:0] enemy_y_pos;
   logic [8:0]  enemy_direction, enemy_facing;
   logic [2:0]  enemy_alive;
   logic [9:0]  rom_addr;
   logic [5:0]  rom_data;
   logic [8:0]  x_draw;
   logic [7:0]  y_draw;
   logic [5:0]  colour;
   logic        VGA_write, draw_done;
   logic [1:0]  draw_state;

   int compared = 0;
   int mismatched = 0;

   // Draw-run statistics
   int done_cyc, done_cnt, writes, first_wr;
   int e0_minx, e0_maxx, e0_miny, e0_maxy, max_xd;
   logic [9:0] addr1;
   logic [1:0] state1, rst_state;
   logic       pre_vga, rst_vga;

   enemy_array #(.NUM_ENEMIES(3), .SPRITE_SIZE(16), .STEP(1), .X_MAX(320), .Y_MAX(240)) dut (
      .clock(clock), .reset(reset), .init(init), .gen_move(gen_move),
      .apply_move(apply_move), .draw(draw), .link_x_pos(link_x_pos),
      .link_y_pos(link_y_pos), .blocked(blocked), .hit(hit),
      .enemy_x_pos(enemy_x_pos), .enemy_y_pos(enemy_y_pos),
      .enemy_direction(enemy_direction), .enemy_facing(enemy_facing),
      .enemy_alive(enemy_alive), .rom_addr(rom_addr), .rom_data(rom_data),
      .x_draw(x_draw), .y_draw(y_draw), .colour(colour),
      .VGA_write(VGA_write), .draw_done(draw_done), .draw_state(draw_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Sprite ROM: column 0 transparent, everything else opaque.
   always @(posedge clock) rom_data <= (rom_addr[3:0] == 4'd0) ? 6'h3F : 6'h15;

   function automatic logic [8:0] gx(input int i);
      return enemy_x_pos[9*i +: 9];
   endfunction
   function automatic logic [7:0] gy(input int i);
      return enemy_y_pos[8*i +: 8];
   endfunction
   function automatic logic [2:0] gd(input int i);
      return enemy_direction[3*i +: 3];
   endfunction
   function automatic logic [2:0] gf(input int i);
      return enemy_facing[3*i +: 3];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_init;
      init = 1'b1; tick; init = 1'b0;
   endtask
   task automatic pulse_gen;
      gen_move = 1'b1; tick; gen_move = 1'b0;
   endtask
   task automatic pulse_apply;
      apply_move = 1'b1; tick; apply_move = 1'b0;
   endtask

   // Runs a draw for a fixed 1200-cycle window. abort_at>0 pulses reset at that
   // cycle; cycle 60 carries a gen_move that must be ignored.
   task automatic run_draw(input int abort_at);
      done_cyc = -1; done_cnt = 0; writes = 0; first_wr = -1; max_xd = 0;
      e0_minx = 999; e0_maxx = -1; e0_miny = 999; e0_maxy = -1;
      pre_vga = 1'b0; rst_vga = 1'b1; rst_state = 2'd3;
      draw = 1'b1; tick; draw = 1'b0;
      for (int cyc = 1; cyc < 1200; cyc++) begin
         if (cyc == 1) begin
            addr1  = rom_addr;
            state1 = draw_state;
         end
         if (cyc == abort_at) begin
            pre_vga = VGA_write;
            reset = 1'b1;
            #1;
            rst_vga   = VGA_write;
            rst_state = draw_state;
            reset = 1'b0;
         end
         if (VGA_write) begin
            writes++;
            if (first_wr < 0) first_wr = cyc;
            if (int'(x_draw) > max_xd) max_xd = int'(x_draw);
            if (writes <= 240) begin
               if (int'(x_draw) < e0_minx) e0_minx = int'(x_draw);
               if (int'(x_draw) > e0_maxx) e0_maxx = int'(x_draw);
               if (int'(y_draw) < e0_miny) e0_miny = int'(y_draw);
               if (int'(y_draw) > e0_maxy) e0_maxy = int'(y_draw);
            end
         end
         if (draw_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         gen_move = (cyc == 60);
         tick;
      end
      gen_move = 1'b0;
   endtask

   initial begin
      reset = 1'b1; init = 0; gen_move = 0; apply_move = 0; draw = 0;
      link_x_pos = '0; link_y_pos = '0; blocked = '0; hit = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      tick;

      check("rst_x", enemy_x_pos, 0);
      check("rst_y", enemy_y_pos, 0);
      check("rst_alive", enemy_alive, 0);
      check("rst_dir", enemy_direction, 0);
      check("rst_facing", enemy_facing, 9'b010_010_010);
      check("rst_vga", VGA_write, 0);
      check("rst_done", draw_done, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_xy_draw", {x_draw, y_draw, colour}, 0);
      check("rst_state", draw_state, 0);

      pulse_init;
      check("init_x0", gx(0), 32);
      check("init_x1", gx(1), 96);
      check("init_x2", gx(2), 160);
      check("init_y", enemy_y_pos, {8'd32, 8'd32, 8'd32});
      check("init_alive", enemy_alive, 3'b111);
      check("init_dir", enemy_direction, 0);
      check("init_facing", enemy_facing, 9'b010_010_010);

      link_x_pos = 9'd100; link_y_pos = 8'd100;
      pulse_gen;
      check("gen_dir0_tie", gd(0), 4);
      check("gen_dir1", gd(1), 2);
      check("gen_dir2", gd(2), 2);
      check("gen_face0", gf(0), 4);

      blocked = 3'b110; hit = 3'b100;
      pulse_apply;
      blocked = '0; hit = '0;
      check("app_x0", gx(0), 33);
      check("app_y0", gy(0), 32);
      check("app_blk_x1", gx(1), 96);
      check("app_blk_y1", gy(1), 32);
      check("app_hit_pos2", {gx(2), gy(2)}, {9'd160, 8'd32});
      check("app_alive", enemy_alive, 3'b011);
      check("app_dir", enemy_direction, 0);
      check("app_face0", gf(0), 4);

      pulse_gen;
      check("gen2_dir0", gd(0), 2);
      check("gen2_dead_dir2", gd(2), 0);
      pulse_apply;
      check("app2_y0", gy(0), 33);
      check("app2_y1", gy(1), 33);

      link_x_pos = 9'd96; link_y_pos = 8'd33;
      pulse_gen;
      check("gen_coincident_dir1", gd(1), 0);
      check("gen_coincident_face1", gf(1), 2);

      // Enemy 2 dead: 2*256 + 1 scan cycles.
      link_x_pos = 9'd0; link_y_pos = 8'd200;
      run_draw(0);
      check("dead_done_cycle", done_cyc, 515);
      check("dead_done_count", done_cnt, 1);
      check("dead_writes", writes, 480);

      pulse_init;
      run_draw(0);
      check("draw_addr1", addr1, 10'h100);
      check("draw_state1", state1, 1);
      check("draw_first_write", first_wr, 3);
      check("draw_done_cycle", done_cyc, 770);
      check("draw_done_count", done_cnt, 1);
      check("draw_writes", writes, 720);
      check("draw_e0_x", {e0_minx[15:0], e0_maxx[15:0]}, {16'd33, 16'd47});
      check("draw_e0_y", {e0_miny[15:0], e0_maxy[15:0]}, {16'd32, 16'd47});
      check("draw_gen_ignored", enemy_direction, 0);
      check("draw_end_state", draw_state, 0);

      pulse_init;
      link_x_pos = 9'd319; link_y_pos = 8'd32;
      repeat (280) begin
         pulse_gen;
         pulse_apply;
      end
      check("clamp_x0", gx(0), 304);
      check("clamp_x2", gx(2), 304);
      pulse_gen;
      check("clamp_dir0", gd(0), 4);
      pulse_apply;
      check("clamp_hold_x0", gx(0), 304);
      check("clamp_y0", gy(0), 32);

      run_draw(100);
      check("abort_pre_vga", pre_vga, 1);
      check("abort_vga", rst_vga, 0);
      check("abort_state", rst_state, 0);
      check("abort_no_done", done_cnt, 0);
      check("abort_max_xdraw", max_xd, 319);
      check("abort_alive", enemy_alive, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
